mlp_sample_sequencer: RTL and testbench



---
 rtl/mlp_sample_sequencer_pkg.sv | 25 ++
 rtl/mlp_sample_sequencer_if.sv | 26 ++
 rtl/mlp_sample_sequencer_sat_counter.sv | 24 ++
 rtl/mlp_sample_sequencer.sv | 124 ++++++++++++
 tb/tb_mlp_sample_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_sample_sequencer_pkg.sv
// Shared types and constants for the MLP sample sequencer: FSM state encoding,
// default classifier geometry and the saturating increment used by the counters.
package mlp_sample_sequencer_pkg;

  localparam int N_FEAT  = 4;
  localparam int FEAT_W  = 4;
  localparam int CLS_W   = 2;
  localparam int N_CLASS = 3;
  localparam int CNT_W   = 16;

  // Widest counter the shared increment helper supports.
  localparam int SAT_W   = 32;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max_v);
    return (v >= max_v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mlp_sample_sequencer_if.sv
// Feature-stream and result handshakes of the sequencer. The DUT takes the
// slave side; the feature producer / result consumer takes the master side.
interface mlp_sample_sequencer_if #(
  parameter int FEAT_W = 4,
  parameter int CLS_W  = 2
);
  logic              s_valid;
  logic              s_ready;
  logic [FEAT_W-1:0] s_feat;
  logic [CLS_W-1:0]  s_label;
  logic              r_valid;
  logic              r_ready;
  logic [CLS_W-1:0]  r_class;
  logic              r_match;
  logic              r_illegal;

  modport master (
    output s_valid, s_feat, s_label, r_ready,
    input  s_ready, r_valid, r_class, r_match, r_illegal
  );

  modport slave (
    input  s_valid, s_feat, s_label, r_ready,
    output s_ready, r_valid, r_class, r_match, r_illegal
  );
endinterface

// File: rtl/mlp_sample_sequencer_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping; clear beats
// increment so a cleared result is never counted.
module sat_counter
  import mlp_sample_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [SAT_W-1:0] MAX_V = SAT_W'({CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc)
      cnt <= CNT_W'(sat_inc(SAT_W'(cnt), MAX_V));
  end

endmodule

// File: rtl/mlp_sample_sequencer.sv
// Packs a feature stream into the classifier input word, samples the class
// index once it settles, holds the result for the consumer and keeps stats.
module mlp_sample_sequencer
  import mlp_sample_sequencer_pkg::*;
#(
  parameter int N_FEAT  = mlp_sample_sequencer_pkg::N_FEAT,
  parameter int FEAT_W  = mlp_sample_sequencer_pkg::FEAT_W,
  parameter int CLS_W   = mlp_sample_sequencer_pkg::CLS_W,
  parameter int N_CLASS = mlp_sample_sequencer_pkg::N_CLASS,
  parameter int CNT_W   = mlp_sample_sequencer_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  mlp_sample_sequencer_if.slave      sif,
  output logic [N_FEAT*FEAT_W-1:0]   cls_inp,
  input  logic [CLS_W-1:0]           cls_out,
  output logic [CNT_W-1:0]           sample_cnt,
  output logic [CNT_W-1:0]           hit_cnt,
  output logic [N_CLASS*CNT_W-1:0]   pred_cnt
);

  localparam int                IDX_W    = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FEAT - 1);
  // One extra bit so N_CLASS == 2**CLS_W still compares correctly.
  localparam logic [CLS_W:0]    NCLS     = (CLS_W + 1)'(N_CLASS);

  seq_state_t          state, state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [CLS_W-1:0]    label;
  logic                load_fire;
  logic                res_fire;
  logic [N_CLASS-1:0]  pred_inc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  // Handshake outputs depend on state only: no s_valid->s_ready or
  // r_ready->r_valid combinational path.
  always_comb begin
    state_nxt   = state;
    sif.s_ready = 1'b0;
    sif.r_valid = 1'b0;
    case (state)
      LOAD: begin
        sif.s_ready = 1'b1;
        if (sif.s_valid && (idx == LAST_IDX)) state_nxt = EVAL;
      end
      EVAL: state_nxt = HOLD;
      HOLD: begin
        sif.r_valid = 1'b1;
        if (sif.r_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign load_fire = sif.s_valid && sif.s_ready;
  assign res_fire  = sif.r_valid && sif.r_ready;

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      label         <= '0;
      cls_inp       <= '0;
      sif.r_class   <= '0;
      sif.r_match   <= 1'b0;
      sif.r_illegal <= 1'b0;
    end else begin
      if (load_fire) begin
        cls_inp[idx*FEAT_W +: FEAT_W] <= sif.s_feat;
        if (idx == LAST_IDX) begin
          idx   <= '0;
          label <= sif.s_label;
        end else begin
          idx   <= idx + 1'b1;
        end
      end
      // Classifier has had the whole EVAL cycle to settle on the stable word.
      if (state == EVAL) begin
        sif.r_class   <= cls_out;
        sif.r_illegal <= ({1'b0, cls_out} >= NCLS);
        sif.r_match   <= (cls_out == label) && ({1'b0, label} < NCLS);
      end
    end
  end

  // ---------------------------------------------------------- statistics
  for (genvar k = 0; k < N_CLASS; k++) begin : g_pred_inc
    assign pred_inc[k] = res_fire && !sif.r_illegal &&
                         ({1'b0, sif.r_class} == (CLS_W + 1)'(k));
  end

  sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (res_fire),
    .cnt (sample_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (res_fire && sif.r_match),
    .cnt (hit_cnt)
  );

  for (genvar k = 0; k < N_CLASS; k++) begin : g_pred_cnt
    sat_counter #(.CNT_W(CNT_W)) u_pred_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (pred_inc[k]),
      .cnt (pred_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// Directed + randomized bench for mlp_sample_sequencer; a second narrow-counter
// instance runs in lockstep so counter saturation is reachable in few samples.
module tb_mlp_sample_sequencer;

  localparam int N_FEAT  = 4;
  localparam int FEAT_W  = 4;
  localparam int CLS_W   = 2;
  localparam int N_CLASS = 3;
  localparam int CNT_W   = 16;
  localparam int SCNT_W  = 3;
  localparam int MAX_BIG = 65535;
  localparam int MAX_SML = 7;

  logic clk = 1'b0;
  logic rst, clr, force_ill;
  always #5 clk = ~clk;

  mlp_sample_sequencer_if #(.FEAT_W(FEAT_W), .CLS_W(CLS_W)) sif ();
  mlp_sample_sequencer_if #(.FEAT_W(FEAT_W), .CLS_W(CLS_W)) sif2 ();

  logic [15:0] cls_inp, cls_inp2;
  logic [1:0]  cls_out, cls_out2;
  logic [CNT_W-1:0]          sample_cnt, hit_cnt;
  logic [N_CLASS*CNT_W-1:0]  pred_cnt;
  logic [SCNT_W-1:0]         s_sample_cnt, s_hit_cnt;
  logic [N_CLASS*SCNT_W-1:0] s_pred_cnt;

  // Stand-in for the external classifier: a fixed weighted sum mod 3.
  function automatic logic [1:0] clsf(input logic [15:0] w);
    int s;
    s = int'(w[3:0]) + 2 * int'(w[7:4]) + int'(w[11:8]) + 2 * int'(w[15:12]);
    return 2'(s % 3);
  endfunction

  assign cls_out  = force_ill ? 2'b11 : clsf(cls_inp);
  assign cls_out2 = force_ill ? 2'b11 : clsf(cls_inp2);

  assign sif2.s_valid = sif.s_valid;
  assign sif2.s_feat  = sif.s_feat;
  assign sif2.s_label = sif.s_label;
  assign sif2.r_ready = sif.r_ready;

  mlp_sample_sequencer #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLS_W(CLS_W),
                         .N_CLASS(N_CLASS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr), .sif(sif),
    .cls_inp(cls_inp), .cls_out(cls_out),
    .sample_cnt(sample_cnt), .hit_cnt(hit_cnt), .pred_cnt(pred_cnt)
  );

  mlp_sample_sequencer #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLS_W(CLS_W),
                         .N_CLASS(N_CLASS), .CNT_W(SCNT_W)) dut_small (
    .clk(clk), .rst(rst), .clr(clr), .sif(sif2),
    .cls_inp(cls_inp2), .cls_out(cls_out2),
    .sample_cnt(s_sample_cnt), .hit_cnt(s_hit_cnt), .pred_cnt(s_pred_cnt)
  );

  // Reference model: current feature slots and true event counts since clear.
  logic [3:0] feats [4];
  int n_s, n_h;
  int n_p [3];
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] model_word();
    return {feats[3], feats[2], feats[1], feats[0]};
  endfunction

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic chk_cnt(input string ph);
    chk({ph, "_sample"}, 64'(sample_cnt), 64'(sat(n_s, MAX_BIG)));
    chk({ph, "_hit"},    64'(hit_cnt),    64'(sat(n_h, MAX_BIG)));
    chk({ph, "_ssample"}, 64'(s_sample_cnt), 64'(sat(n_s, MAX_SML)));
    chk({ph, "_shit"},    64'(s_hit_cnt),    64'(sat(n_h, MAX_SML)));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_pred%0d", ph, k), 64'(pred_cnt[k*CNT_W +: CNT_W]),
          64'(sat(n_p[k], MAX_BIG)));
      chk($sformatf("%s_spred%0d", ph, k), 64'(s_pred_cnt[k*SCNT_W +: SCNT_W]),
          64'(sat(n_p[k], MAX_SML)));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) feats[i] = 4'h0;
    n_s = 0; n_h = 0;
    for (int k = 0; k < 3; k++) n_p[k] = 0;
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, "_s_ready"},   64'(sif.s_ready), 64'(1));
    chk({ph, "_r_valid"},   64'(sif.r_valid), 64'(0));
    chk({ph, "_r_class"},   64'(sif.r_class), 64'(0));
    chk({ph, "_r_match"},   64'(sif.r_match), 64'(0));
    chk({ph, "_r_illegal"}, 64'(sif.r_illegal), 64'(0));
    chk({ph, "_cls_inp"},   64'(cls_inp), 64'(0));
    chk_cnt(ph);
  endtask

  // One feature beat at slot i, optionally preceded by an idle cycle.
  task automatic beat(input int i, input logic [3:0] f, input logic [1:0] lab, input bit gap);
    if (gap) begin
      sif.s_valid = 1'b0;
      sif.s_feat  = 4'($urandom);
      @(posedge clk); #1;
      chk("idle_cls_inp", 64'(cls_inp), 64'(model_word()));
    end
    chk("load_s_ready", 64'(sif.s_ready), 64'(1));
    chk("load_r_valid", 64'(sif.r_valid), 64'(0));
    sif.s_valid = 1'b1;
    sif.s_feat  = f;
    sif.s_label = lab;
    feats[i]    = f;
    @(posedge clk); #1;
  endtask

  task automatic sample(input logic [15:0] word, input int label, input int stall,
                        input bit with_clr, input bit gaps);
    int exp_cls;
    bit exp_ill, exp_match;
    for (int i = 0; i < 4; i++)
      beat(i, word[i*4 +: 4], (i == 3) ? 2'(label) : 2'($urandom),
           gaps && ($urandom_range(0, 1) == 1));
    // EVAL cycle: word complete, no result yet, no beats taken.
    sif.s_valid = 1'b1;
    sif.s_feat  = 4'($urandom);
    chk("eval_cls_inp", 64'(cls_inp), 64'(model_word()));
    chk("eval_r_valid", 64'(sif.r_valid), 64'(0));
    chk("eval_s_ready", 64'(sif.s_ready), 64'(0));
    exp_cls   = force_ill ? 3 : int'(clsf(model_word()));
    exp_ill   = (exp_cls >= N_CLASS);
    exp_match = (exp_cls == label) && (label < N_CLASS);
    @(posedge clk); #1;
    for (int c = 0; c <= stall; c++) begin
      chk("hold_r_valid",   64'(sif.r_valid), 64'(1));
      chk("hold_s_ready",   64'(sif.s_ready), 64'(0));
      chk("hold_r_class",   64'(sif.r_class), 64'(exp_cls));
      chk("hold_r_match",   64'(sif.r_match), 64'(exp_match));
      chk("hold_r_illegal", 64'(sif.r_illegal), 64'(exp_ill));
      chk("hold_cls_inp",   64'(cls_inp), 64'(model_word()));
      chk_cnt("hold");
      if (c < stall) begin
        sif.s_feat = 4'($urandom);
        @(posedge clk); #1;
      end
    end
    sif.r_ready = 1'b1;
    clr         = with_clr;
    @(posedge clk); #1;
    sif.r_ready = 1'b0;
    sif.s_valid = 1'b0;
    clr         = 1'b0;
    if (with_clr) begin
      n_s = 0; n_h = 0;
      for (int k = 0; k < 3; k++) n_p[k] = 0;
    end else begin
      n_s++;
      if (exp_match) n_h++;
      if (!exp_ill) n_p[exp_cls]++;
    end
    chk("post_r_valid", 64'(sif.r_valid), 64'(0));
    chk("post_s_ready", 64'(sif.s_ready), 64'(1));
    chk("post_cls_inp", 64'(cls_inp), 64'(model_word()));
    chk("post_small_inp", 64'(cls_inp2), 64'(model_word()));
    chk_cnt("post");
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1; clr = 1'b0; force_ill = 1'b0;
    sif.s_valid = 1'b0; sif.s_feat = '0; sif.s_label = '0; sif.r_ready = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_reset("reset");

    // Directed: features 1,2,3,4 label 2 -> word 16'h4321.
    sample(16'h4321, 2, 0, 1'b0, 1'b0);
    chk("word_4321", 64'(cls_inp), 64'(16'h4321));

    // Backpressure: 10 stall cycles in HOLD.
    sample(16'($urandom), int'($urandom_range(0, 2)), 10, 1'b0, 1'b0);

    // Illegal label never matches.
    sample(16'($urandom), 3, 1, 1'b0, 1'b0);

    // Classifier stuck at 2'b11.
    force_ill = 1'b1;
    sample(16'($urandom), 0, 0, 1'b0, 1'b0);
    force_ill = 1'b0;

    // Matching samples: drives the narrow instance into saturation.
    for (int n = 0; n < 10; n++) begin
      w = 16'($urandom);
      sample(w, int'(clsf(w)), 0, 1'b0, 1'b0);
    end

    // Randomized traffic with gaps, stalls, bad labels and faults.
    for (int n = 0; n < 16; n++) begin
      force_ill = ($urandom_range(0, 7) == 0);
      w = 16'($urandom);
      sample(w, ($urandom_range(0, 1) == 1) ? int'(clsf(w)) : int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), 1'b0, 1'b1);
    end
    force_ill = 1'b0;

    // clr coinciding with a handshake wins; next sample counts from zero.
    sample(16'($urandom), 1, 2, 1'b1, 1'b0);
    w = 16'($urandom);
    sample(w, int'(clsf(w)), 0, 1'b0, 1'b0);

    // Partial word keeps old upper features, then rst discards it.
    beat(0, 4'hA, 2'd0, 1'b0);
    beat(1, 4'h5, 2'd0, 1'b0);
    sif.s_valid = 1'b0;
    chk("partial_word", 64'(cls_inp), 64'(model_word()));
    pulse_rst();
    chk_reset("rst_mid");
    sample(16'h1234, 1, 0, 1'b0, 1'b0);

    // rst while a result is held.
    for (int i = 0; i < 4; i++) beat(i, 4'($urandom), 2'd1, 1'b0);
    sif.s_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_r_valid", 64'(sif.r_valid), 64'(1));
    pulse_rst();
    chk_reset("rst_hold");
    w = 16'($urandom);
    sample(w, int'(clsf(w)), 1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
